op_frame_parser: RTL and testbench

OP_FRAME_PARSER -- requirements
Module: op_frame_parser

---
 rtl/op_frame_pkg.sv | 37 +++
 rtl/op_frame_chk.sv | 43 ++++
 rtl/op_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_op_frame_parser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_frame_pkg.sv
// Shared types and constants for the opcode frame parser.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package op_frame_pkg;

   // Default data/operand width in bits
   localparam int OP_FRAME_W_DEFAULT = 8;

   // Opcode carried in bits [2:0] of the first frame byte
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_NOT = 3'd7
   } op_t;

   // Parser states; the checksum state exists only in checksum builds
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_A   = 3'd1,
      ST_GET_B   = 3'd2,
`ifdef OP_FRAME_CHECKSUM_EN
      ST_GET_CHK = 3'd3,
`endif
      ST_HOLD    = 3'd4
   } state_t;

   // Saturating 8-bit increment used by the rejection counter
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/op_frame_chk.sv
// XOR checksum accumulator over the opcode, A and B bytes of a frame.
// Latency: accumulator updates on the clock edge; match is combinational on din.
// Backpressure: none; the parser decides when a byte is accepted.
module op_frame_chk
   import op_frame_pkg::*;
#(
   parameter int W = OP_FRAME_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         acc_en,
   input  logic [W-1:0] din,
   output logic         match
);

   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   // Next accumulator: clear+accumulate together loads the first byte of a new frame
   always_comb begin
      acc_d = acc_q;
      if (clr && acc_en) begin
         acc_d = din;
      end else if (clr) begin
         acc_d = '0;
      end else if (acc_en) begin
         acc_d = acc_q ^ din;
      end
   end

   // Accumulator register, cleared by the asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign match = (acc_q == din);

endmodule

// File: rtl/op_frame_parser.sv
// Parses opcode/A/B byte frames (optional trailing XOR checksum with OP_FRAME_CHECKSUM_EN).
// Latency: out_valid rises the cycle after the last frame byte; frame period = bytes + 1.
// Backpressure: in_ready drops while a parsed frame waits in HOLD for out_ready.
module op_frame_parser
   import op_frame_pkg::*;
#(
   parameter int W = OP_FRAME_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [2:0]   out_op,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         err,
   output logic [7:0]   frame_cnt,
   output logic [7:0]   err_cnt
);

   state_t       state_q, state_d;
   op_t          op_q, op_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic         err_q, err_d;
   logic [7:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]   err_cnt_q, err_cnt_d;

   logic         xfer;
   logic         hdr_ok;

   assign xfer   = in_valid & in_ready;
   // Opcode byte is only legal when every bit above the 3-bit opcode is zero
   assign hdr_ok = (in_data[W-1:3] == '0);

`ifdef OP_FRAME_CHECKSUM_EN
   logic chk_clr;
   logic chk_acc;
   logic chk_match;

   op_frame_chk #(
      .W (W)
   ) u_chk (
      .clk    (clk),
      .rst    (rst),
      .clr    (chk_clr),
      .acc_en (chk_acc),
      .din    (in_data),
      .match  (chk_match)
   );
`endif

   // Next-state, datapath capture, counters and handshake outputs
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      err_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      in_ready    = 1'b1;
      out_valid   = 1'b0;
`ifdef OP_FRAME_CHECKSUM_EN
      chk_clr     = 1'b0;
      chk_acc     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               op_d = op_t'(in_data[2:0]);
               if (hdr_ok) begin
                  state_d = ST_GET_A;
`ifdef OP_FRAME_CHECKSUM_EN
                  chk_clr = 1'b1;
                  chk_acc = 1'b1;
`endif
               end else begin
                  // Bad opcode byte: flag it and stay ready for the next frame start
                  err_d     = 1'b1;
                  err_cnt_d = sat_inc8(err_cnt_q);
               end
            end
         end
         ST_GET_A: begin
            if (xfer) begin
               a_d     = in_data;
               state_d = ST_GET_B;
`ifdef OP_FRAME_CHECKSUM_EN
               chk_acc = 1'b1;
`endif
            end
         end
         ST_GET_B: begin
            if (xfer) begin
               b_d = in_data;
`ifdef OP_FRAME_CHECKSUM_EN
               chk_acc = 1'b1;
               state_d = ST_GET_CHK;
`else
               state_d = ST_HOLD;
`endif
            end
         end
`ifdef OP_FRAME_CHECKSUM_EN
         ST_GET_CHK: begin
            if (xfer) begin
               if (chk_match) begin
                  state_d = ST_HOLD;
               end else begin
                  // Corrupt frame is dropped; captured fields are simply overwritten later
                  err_d     = 1'b1;
                  err_cnt_d = sat_inc8(err_cnt_q);
                  state_d   = ST_IDLE;
               end
            end
         end
`endif
         ST_HOLD: begin
            // Frame fields are frozen here: nothing above writes them in this state
            in_ready  = 1'b0;
            out_valid = 1'b1;
            if (out_ready) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial or pending frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= 8'd0;
         err_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_op    = op_q;
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign err       = err_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_op_frame_parser.sv
// Directed self-checking bench for op_frame_parser.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and in_ready drop in HOLD.
module tb_op_frame_parser;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   out_op;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         err;
   logic [7:0]   frame_cnt;
   logic [7:0]   err_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   op_frame_parser #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_op    (out_op),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until accepted (bounded wait)
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_wait: in_ready=%b required 1 for byte %h", in_ready, b);
      end
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      send(op);
      send(a);
      send(b);
`ifdef OP_FRAME_CHECKSUM_EN
      send(op ^ a ^ b);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
      tests++; if ({out_op, out_a, out_b} !== 19'd0) begin fails++; $display("FAIL rst_fields: got %h/%h/%h want 0/0/0", out_op, out_a, out_b); end
      tests++; if ({frame_cnt, err_cnt} !== 16'd0) begin fails++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", frame_cnt, err_cnt); end
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(8'h00);
      send(8'h05);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      send(8'h03);
`ifdef OP_FRAME_CHECKSUM_EN
      send(8'h06);
`endif
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      tests++; if ({out_op, out_a, out_b} !== {3'd0, 8'h05, 8'h03}) begin fails++; $display("FAIL basic_fields: got %h/%h/%h want 0/05/03", out_op, out_a, out_b); end
      cyc();
      tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_idle: valid=%b ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_err();
      send(8'h1A);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", err); end
      tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL err_cnt: got %0d want 1", err_cnt); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL err_in_ready: got %b want 1", in_ready); end
      cyc();
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_one_cycle: got %b want 0", err); end
      send_frame(8'h02, 8'hF0, 8'h0F);
      tests++; if ({out_valid, out_op, out_a, out_b} !== {1'b1, 3'd2, 8'hF0, 8'h0F}) begin fails++; $display("FAIL err_next_frame: got v=%b %h/%h/%h want 1 2/f0/0f", out_valid, out_op, out_a, out_b); end
      cyc();
      tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL err_frame_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_frame(8'h04, 8'h11, 8'h22);
      // Junk offered while holding must not be taken
      in_data  = 8'h99;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({out_valid, in_ready, out_op, out_a, out_b} !== {1'b1, 1'b0, 3'd4, 8'h11, 8'h22}) begin
            fails++;
            $display("FAIL bp_hold_%0d: got v=%b r=%b %h/%h/%h want 1 0 4/11/22", i, out_valid, in_ready, out_op, out_a, out_b);
         end
         if (i < 4) cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: v=%b r=%b want 0/1", out_valid, in_ready); end
      tests++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL bp_frame_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_reset_mid();
      send(8'h01);
      send(8'h10);
      rst = 1'b0;
      #1;
      tests++; if ({err, out_valid, frame_cnt, err_cnt} !== 18'd0) begin fails++; $display("FAIL mid_rst: err=%b v=%b fc=%0d ec=%0d want 0", err, out_valid, frame_cnt, err_cnt); end
      tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL mid_rst_a: got %h want 00", out_a); end
      cyc();
      rst = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      send_frame(8'h07, 8'hAA, 8'h55);
      tests++; if ({out_valid, out_op, out_a, out_b} !== {1'b1, 3'd7, 8'hAA, 8'h55}) begin fails++; $display("FAIL mid_frame: got v=%b %h/%h/%h want 1 7/aa/55", out_valid, out_op, out_a, out_b); end
      cyc();
      tests++; if ({frame_cnt, err} !== {8'd1, 1'b0}) begin fails++; $display("FAIL mid_cnt: fc=%0d err=%b want 1/0", frame_cnt, err); end
   endtask

   task automatic test_reset_hold();
      out_ready = 1'b0;
      send_frame(8'h05, 8'h01, 8'h02);
      rst = 1'b0;
      #1;
      tests++; if ({out_valid, err, frame_cnt} !== 10'd0) begin fails++; $display("FAIL hold_rst: v=%b err=%b fc=%0d want 0", out_valid, err, frame_cnt); end
      cyc();
      rst = 1'b1;
      cyc();
      tests++; if ({out_valid, in_ready, err} !== 3'b010) begin fails++; $display("FAIL hold_after_rst: v=%b r=%b err=%b want 0/1/0", out_valid, in_ready, err); end
      out_ready = 1'b1;
   endtask

   task automatic test_frame_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         send_frame(8'h01, i[7:0], ~i[7:0]);
         cyc();
      end
      tests++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
      send_frame(8'h06, 8'h3C, 8'hC3);
      tests++; if ({out_op, out_a, out_b} !== {3'd6, 8'h3C, 8'hC3}) begin fails++; $display("FAIL wrap_fields: got %h/%h/%h want 6/3c/c3", out_op, out_a, out_b); end
      cyc();
      tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d want 0", frame_cnt); end
   endtask

   task automatic test_err_sat();
      do_reset();
      for (int i = 0; i < 255; i++) send(8'hF8);
      tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
      for (int i = 0; i < 45; i++) send(8'h08);
      tests++; if ({err, err_cnt} !== {1'b1, 8'd255}) begin fails++; $display("FAIL sat_300: err=%b ec=%0d want 1/255", err, err_cnt); end
      send_frame(8'h03, 8'h01, 8'h01);
      cyc();
      tests++; if ({frame_cnt, err_cnt, err} !== {8'd1, 8'd255, 1'b0}) begin fails++; $display("FAIL sat_indep: fc=%0d ec=%0d err=%b want 1/255/0", frame_cnt, err_cnt, err); end
   endtask

`ifdef OP_FRAME_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      out_ready = 1'b1;
      send(8'h03); send(8'h0F); send(8'hF0); send(8'hFC);
      tests++; if ({out_valid, out_op, out_a, out_b} !== {1'b1, 3'd3, 8'h0F, 8'hF0}) begin fails++; $display("FAIL chk_good: got v=%b %h/%h/%h want 1 3/0f/f0", out_valid, out_op, out_a, out_b); end
      cyc();
      send(8'h03); send(8'h0F); send(8'hF0); send(8'h00);
      tests++; if ({err, out_valid, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin fails++; $display("FAIL chk_bad: err=%b v=%b ec=%0d want 1/0/1", err, out_valid, err_cnt); end
      cyc();
      tests++; if ({out_valid, frame_cnt} !== {1'b0, 8'd1}) begin fails++; $display("FAIL chk_drop: v=%b fc=%0d want 0/1", out_valid, frame_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_err();
      test_backpressure();
      test_reset_mid();
      test_reset_hold();
      test_frame_wrap();
      test_err_sat();
`ifdef OP_FRAME_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
